// File: rtl/fsk_zero_cross_demod.sv
// -----------------------------------------------------------------------------
// fsk_zero_cross_demod
//
// Recovers FSK bits from a signed carrier sample stream. It measures the number
// of valid samples between successive rising zero crossings, with a hysteresis
// band around zero. Short periods decode as 1 and long periods decode as 0.
// A period counter that saturates flags loss of carrier.
//
// Parameters
//   W          sample width (two's complement)
//   CNT_W      period counter width; the counter saturates at 2^CNT_W-1
//   HYST       hysteresis magnitude; a sample must lie strictly beyond +/-HYST
//   THRESH     a period <= THRESH decodes as 1, a longer period decodes as 0
//   MIN_PERIOD a period shorter than this is treated as a glitch and dropped
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   sample_valid  qualifies sample this cycle
//   sample        signed carrier sample
//   period_valid  one-cycle pulse when a new period is accepted
//   period_out    last accepted period in samples (held)
//   bit_out       decoded bit of the last accepted period (held)
//   carrier_lost  level; set on counter saturation, cleared by the next
//                 accepted period
// -----------------------------------------------------------------------------
module fsk_zero_cross_demod #(
    parameter int W          = 8,
    parameter int CNT_W      = 10,
    parameter int HYST       = 4,
    parameter int THRESH     = 192,
    parameter int MIN_PERIOD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic signed [W-1:0] sample,
    output logic                period_valid,
    output logic [CNT_W-1:0]    period_out,
    output logic                bit_out,
    output logic                carrier_lost
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEG  = 2'd1,
        ST_POS  = 2'd2
    } state_t;

    localparam logic signed [W-1:0] C_HYST_POS = W'(HYST);
    localparam logic signed [W-1:0] C_HYST_NEG = -C_HYST_POS;
    localparam logic [CNT_W-1:0]    C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    C_MIN_PER  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]    C_THRESH   = CNT_W'(THRESH);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_period_valid;
    logic [CNT_W-1:0] r_period_out;
    logic             r_bit_out;
    logic             r_carrier_lost;

    logic             w_above;
    logic             w_below;
    logic             w_rise;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_sat;
    state_t           w_state_nxt;

    // Hysteresis comparisons, crossing detect and the candidate period.
    // w_cnt_inc doubles as the measured period P = cnt + 1. The counter is
    // cleared when it reaches the maximum value, so this addition never wraps.
    always_comb begin
        w_above   = (sample > C_HYST_POS);
        w_below   = (sample < C_HYST_NEG);
        w_rise    = (r_state == ST_NEG) && w_above;
        w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_sat     = (w_cnt_inc == C_CNT_MAX);
    end

    // Next polarity state; samples inside the hysteresis band never move it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_above) begin
                    w_state_nxt = ST_POS;
                end else if (w_below) begin
                    w_state_nxt = ST_NEG;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_NEG: begin
                if (w_above) begin
                    w_state_nxt = ST_POS;
                end else begin
                    w_state_nxt = ST_NEG;
                end
            end
            ST_POS: begin
                if (w_below) begin
                    w_state_nxt = ST_NEG;
                end else begin
                    w_state_nxt = ST_POS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Polarity state, period counter, arming and all registered outputs.
    // Saturation takes priority over a coincident crossing. The first crossing
    // after reset or carrier loss only arms the detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_armed        <= 1'b0;
            r_period_valid <= 1'b0;
            r_period_out   <= {CNT_W{1'b0}};
            r_bit_out      <= 1'b0;
            r_carrier_lost <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (sample_valid) begin
                if (w_sat) begin
                    r_carrier_lost <= 1'b1;
                    r_state        <= ST_IDLE;
                    r_armed        <= 1'b0;
                    r_cnt          <= {CNT_W{1'b0}};
                end else begin
                    r_state <= w_state_nxt;
                    if (w_rise && !r_armed) begin
                        r_armed <= 1'b1;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else if (w_rise && (w_cnt_inc >= C_MIN_PER)) begin
                        r_period_valid <= 1'b1;
                        r_period_out   <= w_cnt_inc;
                        r_bit_out      <= (w_cnt_inc <= C_THRESH);
                        r_carrier_lost <= 1'b0;
                        r_cnt          <= {CNT_W{1'b0}};
                    end else begin
                        // Ordinary sample or glitch crossing: keep counting.
                        r_cnt <= w_cnt_inc;
                    end
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign period_valid = r_period_valid;
    assign period_out   = r_period_out;
    assign bit_out      = r_bit_out;
    assign carrier_lost = r_carrier_lost;

endmodule

// File: tb/tb_fsk_zero_cross_demod.sv
// -----------------------------------------------------------------------------
// Bench for fsk_zero_cross_demod. Stimulus is driven on the falling edge. A
// reference model tracks crossings by sample index: a period is the distance
// between the index of the current valid sample and the index at which the
// measurement last restarted. Accepted periods are queued, and a monitor pops
// one entry each time the DUT pulses period_valid.
// -----------------------------------------------------------------------------
module tb_fsk_zero_cross_demod;

    localparam int W      = 8;
    localparam int CNT_W  = 10;
    localparam int HYST   = 4;
    localparam int THRESH = 192;
    localparam int MINP   = 16;
    localparam int SATV   = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [W-1:0] sample = '0;
    logic               period_valid;
    logic [CNT_W-1:0]   period_out;
    logic               bit_out;
    logic               carrier_lost;

    fsk_zero_cross_demod #(
        .W(W), .CNT_W(CNT_W), .HYST(HYST), .THRESH(THRESH), .MIN_PERIOD(MINP)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period_valid(period_valid), .period_out(period_out),
        .bit_out(bit_out), .carrier_lost(carrier_lost)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int n_idx  = 0;   // index of the most recent valid sample since reset
    int base   = 0;   // index where the current measurement restarted
    int pol    = 0;   // last significant polarity: -1, 0 (unknown), +1
    bit armed  = 1'b0;
    int m_per  = 0;
    bit m_bit  = 1'b0;
    bit m_lost = 1'b0;
    bit exp_pv = 1'b0;
    int q_per[$];
    bit q_bit[$];

    // Gap control
    bit gap3    = 1'b0;
    bit gap_rnd = 1'b0;
    int gcnt    = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_idx = 0; base = 0; pol = 0; armed = 1'b0;
        m_per = 0; m_bit = 1'b0; m_lost = 1'b0; exp_pv = 1'b0;
    endtask

    task automatic model_sample(int s);
        int p;
        n_idx++;
        p = n_idx - base;
        if (p == SATV) begin
            m_lost = 1'b1; pol = 0; armed = 1'b0; base = n_idx;
        end else begin
            if (pol == -1 && s > HYST) begin
                if (!armed) begin
                    armed = 1'b1; base = n_idx;
                end else if (p >= MINP) begin
                    m_per = p; m_bit = (p <= THRESH); m_lost = 1'b0;
                    base = n_idx; exp_pv = 1'b1;
                    q_per.push_back(p); q_bit.push_back(p <= THRESH);
                end
            end
            if (s > HYST) pol = 1;
            else if (s < -HYST) pol = -1;
        end
    endtask

    // One cycle: check held outputs against the model, then drive new inputs.
    task automatic step(bit v, int s);
        @(negedge clk);
        chk("period_valid", int'(period_valid), int'(exp_pv));
        chk("period_out",   int'(period_out),   m_per);
        chk("bit_out",      int'(bit_out),      int'(m_bit));
        chk("carrier_lost", int'(carrier_lost), int'(m_lost));
        exp_pv = 1'b0;
        sample_valid = v;
        sample = W'(s);
        if (v) model_sample(s);
    endtask

    task automatic vstep(int s);
        if (gap3) begin
            gcnt++;
            if (gcnt % 3 == 0) step(1'b0, int'($urandom_range(0, 255)) - 128);
        end
        if (gap_rnd && $urandom_range(0, 3) == 0) step(1'b0, int'($urandom_range(0, 255)) - 128);
        step(1'b1, s);
    endtask

    task automatic square(int per, int ncyc, int amp);
        for (int c = 0; c < ncyc; c++)
            for (int k = 0; k < per; k++)
                vstep((k < per / 2) ? -amp : amp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b0;
        #1;
        chk("rst_period_valid", int'(period_valid), 0);
        chk("rst_period_out",   int'(period_out),   0);
        chk("rst_bit_out",      int'(bit_out),      0);
        chk("rst_carrier_lost", int'(carrier_lost), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Scoreboard monitor: each period_valid pulse must match the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && period_valid) begin
                if (q_per.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: pulse with period_out=%0d, none expected", period_out);
                end else begin
                    chk("sb_period", int'(period_out), q_per.pop_front());
                    chk("sb_bit",    int'(bit_out),    int'(q_bit.pop_front()));
                    chk("sb_lost_clr", int'(carrier_lost), 0);
                end
            end
        end
    end

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        chk("por_period_valid", int'(period_valid), 0);
        chk("por_period_out",   int'(period_out),   0);
        chk("por_bit_out",      int'(bit_out),      0);
        chk("por_carrier_lost", int'(carrier_lost), 0);
        rst = 1'b1;

        // 128-sample square carrier, 4 cycles
        square(128, 4, 100);
        step(1'b0, 0);
        chk("t1_period", int'(period_out), 128);
        chk("t1_bit", int'(bit_out), 1);

        // Three cycles at 128 then switch to 256
        square(128, 3, 100);
        square(256, 3, 100);
        step(1'b0, 0);
        chk("t2_period", int'(period_out), 256);
        chk("t2_bit", int'(bit_out), 0);

        // +/-3 inside hysteresis: no state change, loss after 1023 samples
        do_reset();
        for (int i = 0; i < SATV; i++) begin
            step(1'b1, ((i / 64) % 2 == 0) ? 3 : -3);
            if (i == SATV - 2) begin
                step(1'b0, 0);
                chk("t3_lost_before", int'(carrier_lost), 0);
            end
        end
        step(1'b0, 0);
        chk("t3_lost_after", int'(carrier_lost), 1);
        chk("t3_period_held", int'(period_out), 0);

        // Glitch spike 8 samples after a crossing
        for (int c = 0; c < 5; c++)
            for (int k = 0; k < 128; k++)
                step(1'b1, (c == 2 && k == 72) ? -50 : ((k < 64) ? -100 : 100));
        step(1'b0, 0);
        chk("t4_period", int'(period_out), 128);
        chk("t4_lost_clr", int'(carrier_lost), 0);

        // Constant zero after an armed crossing
        square(128, 2, 100);
        for (int k = 0; k < 64; k++) step(1'b1, -100);
        step(1'b1, 100);
        for (int i = 0; i < SATV; i++) begin
            if (i == SATV - 1) begin
                step(1'b0, 0);
                chk("t5_lost_before", int'(carrier_lost), 0);
            end
            step(1'b1, 0);
        end
        step(1'b0, 0);
        chk("t5_lost_after", int'(carrier_lost), 1);
        square(128, 3, 100);
        step(1'b0, 0);
        chk("t5_lost_cleared", int'(carrier_lost), 0);
        chk("t5_period", int'(period_out), 128);

        // Reset mid-period with a gap every third cycle
        gap3 = 1'b1;
        square(128, 2, 100);
        for (int k = 0; k < 40; k++) vstep(-100);
        do_reset();
        square(128, 4, 100);
        step(1'b0, 0);
        chk("t6_period", int'(period_out), 128);
        gap3 = 1'b0;

        // Randomized carriers, amplitudes, spikes and gaps
        gap_rnd = 1'b1;
        for (int r = 0; r < 24; r++) begin
            int per, amp, ncyc;
            per  = int'($urandom_range(10, 400));
            amp  = int'($urandom_range(2, 120));
            ncyc = int'($urandom_range(1, 3));
            for (int c = 0; c < ncyc; c++)
                for (int k = 0; k < per; k++) begin
                    if ($urandom_range(0, 39) == 0)
                        vstep(int'($urandom_range(0, 255)) - 128);
                    else
                        vstep((k < per / 2) ? -amp : amp);
                end
            if (r == 12) do_reset();
        end
        gap_rnd = 1'b0;

        repeat (3) step(1'b0, 0);
        chk("sb_queue_empty", q_per.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
